// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and types for the common-data-bus writeback arbiter.
package cdb_arbiter_pkg;

    localparam int unsigned ROB_IDX_W_DEF = 4;
    localparam int unsigned DATA_W_DEF    = 32;

    typedef enum logic {
        SRC_RS  = 1'b0,
        SRC_SLB = 1'b1
    } cdb_src_e;

    typedef enum logic {
        PTR_RS  = 1'b0,
        PTR_SLB = 1'b1
    } rr_ptr_e;

    // Winner among full slots; the pointer only matters when both are full.
    function automatic cdb_src_e rr_pick(input logic rs_full, input logic slb_full,
                                         input rr_ptr_e ptr);
        cdb_src_e win;
        if (rs_full && slb_full) begin
            if (ptr == PTR_SLB) win = SRC_SLB;
            else                win = SRC_RS;
        end else if (rs_full) begin
            win = SRC_RS;
        end else begin
            win = SRC_SLB;
        end
        return win;
    endfunction

endpackage

// File: rtl/cdb_slot.sv
// One-entry holding slot for a writeback source; refills on the edge it drains.
module cdb_slot
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned PAY_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy_i,
    input  logic             clear_i,
    input  logic             valid_i,
    input  logic [PAY_W-1:0] data_i,
    input  logic             grant_i,
    output logic             ready_o,
    output logic             full_o,
    output logic [PAY_W-1:0] data_o
);

    logic             full_q, full_d;
    logic [PAY_W-1:0] data_q, data_d;
    logic             take;

    always_comb begin
        ready_o = !full_q || grant_i;
        take    = valid_i && ready_o && rdy_i && !clear_i;
        full_d  = full_q;
        data_d  = data_q;
        if (rdy_i) begin
            if (clear_i) begin
                full_d = 1'b0;
            end else if (take) begin
                full_d = 1'b1;
                data_d = data_i;
            end else if (grant_i) begin
                full_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter merging RS and SLB writebacks onto one registered ROB result port.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned ROB_IDX_W = ROB_IDX_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 Clear_flag,
    input  logic                 rs_valid,
    input  logic [ROB_IDX_W-1:0] rs_rob_id,
    input  logic [DATA_W-1:0]    rs_value,
    input  logic [DATA_W-1:0]    rs_jumppc,
    input  logic                 rs_has_jumppc,
    output logic                 rs_ready,
    input  logic                 slb_valid,
    input  logic [ROB_IDX_W-1:0] slb_rob_id,
    input  logic [DATA_W-1:0]    slb_value,
    output logic                 slb_ready,
    output logic                 cdb_valid,
    output logic                 cdb_src,
    output logic [ROB_IDX_W-1:0] cdb_rob_id,
    output logic [DATA_W-1:0]    cdb_value,
    output logic [DATA_W-1:0]    cdb_jumppc,
    output logic                 cdb_has_jumppc
);

    localparam int unsigned RS_PAY_W  = ROB_IDX_W + 2 * DATA_W + 1;
    localparam int unsigned SLB_PAY_W = ROB_IDX_W + DATA_W;

    logic [RS_PAY_W-1:0]  rs_pay_in, rs_pay;
    logic [SLB_PAY_W-1:0] slb_pay_in, slb_pay;
    logic                 rs_full, slb_full;
    logic                 grant_rs, grant_slb, arb_en;
    cdb_src_e             win;

    logic [ROB_IDX_W-1:0] rs_id_h, slb_id_h;
    logic [DATA_W-1:0]    rs_val_h, rs_jpc_h, slb_val_h;
    logic                 rs_hj_h;

    rr_ptr_e              ptr_q, ptr_d;
    logic                 cdb_valid_q, cdb_valid_d;
    cdb_src_e             cdb_src_q, cdb_src_d;
    logic [ROB_IDX_W-1:0] cdb_rob_id_q, cdb_rob_id_d;
    logic [DATA_W-1:0]    cdb_value_q, cdb_value_d;
    logic [DATA_W-1:0]    cdb_jumppc_q, cdb_jumppc_d;
    logic                 cdb_has_jumppc_q, cdb_has_jumppc_d;

    assign rs_pay_in  = {rs_rob_id, rs_value, rs_jumppc, rs_has_jumppc};
    assign slb_pay_in = {slb_rob_id, slb_value};
    assign {rs_id_h, rs_val_h, rs_jpc_h, rs_hj_h} = rs_pay;
    assign {slb_id_h, slb_val_h}                  = slb_pay;

    cdb_slot #(.PAY_W(RS_PAY_W)) u_rs_slot (
        .clk     (clk),
        .rst     (rst),
        .rdy_i   (rdy),
        .clear_i (Clear_flag),
        .valid_i (rs_valid),
        .data_i  (rs_pay_in),
        .grant_i (grant_rs),
        .ready_o (rs_ready),
        .full_o  (rs_full),
        .data_o  (rs_pay)
    );

    cdb_slot #(.PAY_W(SLB_PAY_W)) u_slb_slot (
        .clk     (clk),
        .rst     (rst),
        .rdy_i   (rdy),
        .clear_i (Clear_flag),
        .valid_i (slb_valid),
        .data_i  (slb_pay_in),
        .grant_i (grant_slb),
        .ready_o (slb_ready),
        .full_o  (slb_full),
        .data_o  (slb_pay)
    );

    // Grant is combinational so a drained slot can accept on the same edge.
    always_comb begin
        win       = rr_pick(rs_full, slb_full, ptr_q);
        arb_en    = rdy && !Clear_flag && (rs_full || slb_full);
        grant_rs  = arb_en && (win == SRC_RS);
        grant_slb = arb_en && (win == SRC_SLB);
    end

    always_comb begin
        ptr_d            = ptr_q;
        cdb_valid_d      = cdb_valid_q;
        cdb_src_d        = cdb_src_q;
        cdb_rob_id_d     = cdb_rob_id_q;
        cdb_value_d      = cdb_value_q;
        cdb_jumppc_d     = cdb_jumppc_q;
        cdb_has_jumppc_d = cdb_has_jumppc_q;
        if (rdy) begin
            cdb_valid_d = grant_rs || grant_slb;
            if (Clear_flag) begin
                ptr_d = PTR_RS;
            end else if (grant_rs) begin
                ptr_d            = PTR_SLB;
                cdb_src_d        = SRC_RS;
                cdb_rob_id_d     = rs_id_h;
                cdb_value_d      = rs_val_h;
                cdb_jumppc_d     = rs_jpc_h;
                cdb_has_jumppc_d = rs_hj_h;
            end else if (grant_slb) begin
                ptr_d            = PTR_RS;
                cdb_src_d        = SRC_SLB;
                cdb_rob_id_d     = slb_id_h;
                cdb_value_d      = slb_val_h;
                cdb_jumppc_d     = '0;
                cdb_has_jumppc_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q            <= PTR_RS;
            cdb_valid_q      <= 1'b0;
            cdb_src_q        <= SRC_RS;
            cdb_rob_id_q     <= '0;
            cdb_value_q      <= '0;
            cdb_jumppc_q     <= '0;
            cdb_has_jumppc_q <= 1'b0;
        end else begin
            ptr_q            <= ptr_d;
            cdb_valid_q      <= cdb_valid_d;
            cdb_src_q        <= cdb_src_d;
            cdb_rob_id_q     <= cdb_rob_id_d;
            cdb_value_q      <= cdb_value_d;
            cdb_jumppc_q     <= cdb_jumppc_d;
            cdb_has_jumppc_q <= cdb_has_jumppc_d;
        end
    end

    assign cdb_valid      = cdb_valid_q;
    assign cdb_src        = cdb_src_q;
    assign cdb_rob_id     = cdb_rob_id_q;
    assign cdb_value      = cdb_value_q;
    assign cdb_jumppc     = cdb_jumppc_q;
    assign cdb_has_jumppc = cdb_has_jumppc_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed vector bench for cdb_arbiter plus a streaming alternation sequence.
module tb_cdb_arbiter;

    logic        clk;
    logic        rst, rdy, Clear_flag;
    logic        rs_valid, rs_has_jumppc, rs_ready;
    logic [3:0]  rs_rob_id;
    logic [31:0] rs_value, rs_jumppc;
    logic        slb_valid, slb_ready;
    logic [3:0]  slb_rob_id;
    logic [31:0] slb_value;
    logic        cdb_valid, cdb_src, cdb_has_jumppc;
    logic [3:0]  cdb_rob_id;
    logic [31:0] cdb_value, cdb_jumppc;

    int checks   = 0;
    int failures = 0;

    cdb_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .Clear_flag     (Clear_flag),
        .rs_valid       (rs_valid),
        .rs_rob_id      (rs_rob_id),
        .rs_value       (rs_value),
        .rs_jumppc      (rs_jumppc),
        .rs_has_jumppc  (rs_has_jumppc),
        .rs_ready       (rs_ready),
        .slb_valid      (slb_valid),
        .slb_rob_id     (slb_rob_id),
        .slb_value      (slb_value),
        .slb_ready      (slb_ready),
        .cdb_valid      (cdb_valid),
        .cdb_src        (cdb_src),
        .cdb_rob_id     (cdb_rob_id),
        .cdb_value      (cdb_value),
        .cdb_jumppc     (cdb_jumppc),
        .cdb_has_jumppc (cdb_has_jumppc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, rdy, clr;
        logic        rv;
        logic [3:0]  rid;
        logic [31:0] rval, rjpc;
        logic        rhj;
        logic        sv;
        logic [3:0]  sid;
        logic [31:0] sval;
        logic        chk_rdy, exp_rr, exp_sr;
        logic [70:0] exp_cdb;
    } vec_t;

    function automatic logic [70:0] cdb(input logic v, input logic s, input logic [3:0] id,
                                        input logic [31:0] val, input logic [31:0] jpc,
                                        input logic hj);
        return {v, s, id, val, jpc, hj};
    endfunction

    function automatic vec_t mk(input logic r, input logic e, input logic c,
                                input logic rv, input logic [3:0] rid,
                                input logic [31:0] rval, input logic [31:0] rjpc,
                                input logic rhj, input logic sv, input logic [3:0] sid,
                                input logic [31:0] sval, input logic chk,
                                input logic er, input logic es, input logic [70:0] ec);
        vec_t t;
        t.rst = r; t.rdy = e; t.clr = c;
        t.rv = rv; t.rid = rid; t.rval = rval; t.rjpc = rjpc; t.rhj = rhj;
        t.sv = sv; t.sid = sid; t.sval = sval;
        t.chk_rdy = chk; t.exp_rr = er; t.exp_sr = es; t.exp_cdb = ec;
        return t;
    endfunction

    function automatic vec_t idle(input logic r, input logic e, input logic c,
                                  input logic chk, input logic er, input logic es,
                                  input logic [70:0] ec);
        return mk(r, e, c, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0,
                  chk, er, es, ec);
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [70:0] cdb_now();
        return {cdb_valid, cdb_src, cdb_rob_id, cdb_value, cdb_jumppc, cdb_has_jumppc};
    endfunction

    vec_t vecs[$];

    initial begin
        logic [70:0] z, h3, h5, ea, hc;
        int rs_sent, slb_sent, emitted;
        logic exp_src;
        logic [3:0] rs_q[$];
        logic [3:0] slb_q[$];
        logic rs_acc, slb_acc;
        logic [3:0] id;

        rst = 1'b1; rdy = 1'b0; Clear_flag = 1'b0;
        rs_valid = 1'b0; rs_rob_id = '0; rs_value = '0; rs_jumppc = '0; rs_has_jumppc = 1'b0;
        slb_valid = 1'b0; slb_rob_id = '0; slb_value = '0;

        z  = cdb(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        h3 = cdb(1'b0, 1'b0, 4'h3, 32'h11, 32'h80, 1'b1);
        h5 = cdb(1'b0, 1'b1, 4'h5, 32'h55, 32'h0, 1'b0);
        ea = cdb(1'b1, 1'b0, 4'hA, 32'hA0, 32'hA4, 1'b1);
        hc = cdb(1'b0, 1'b0, 4'hC, 32'hC0, 32'hC4, 1'b0);

        // reset overriding rdy=0 and Clear_flag
        vecs.push_back(mk(1, 0, 1, 1, 4'h9, 32'h99, 32'h9, 1, 1, 4'h9, 32'h9, 0, 0, 0, z));
        vecs.push_back(idle(0, 1, 0, 1, 1, 1, z));
        // single RS request
        vecs.push_back(mk(0, 1, 0, 1, 4'h3, 32'h11, 32'h80, 1, 0, 4'h0, 32'h0, 1, 1, 1, z));
        vecs.push_back(idle(0, 1, 0, 1, 1, 1, cdb(1, 0, 4'h3, 32'h11, 32'h80, 1)));
        vecs.push_back(idle(0, 1, 0, 1, 1, 1, h3));
        // simultaneous after reset: RS first
        vecs.push_back(idle(1, 1, 0, 0, 0, 0, z));
        vecs.push_back(mk(0, 1, 0, 1, 4'h2, 32'h22, 32'h44, 0, 1, 4'h5, 32'h55, 1, 1, 1, z));
        vecs.push_back(idle(0, 1, 0, 1, 1, 0, cdb(1, 0, 4'h2, 32'h22, 32'h44, 0)));
        vecs.push_back(idle(0, 1, 0, 1, 1, 1, cdb(1, 1, 4'h5, 32'h55, 32'h0, 0)));
        vecs.push_back(idle(0, 1, 0, 1, 1, 1, h5));
        // flush of held SLB id 7, concurrent RS request dropped
        vecs.push_back(mk(0, 1, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 4'h7, 32'h77, 1, 1, 1, h5));
        vecs.push_back(mk(0, 1, 1, 1, 4'h1, 32'h10, 32'h14, 1, 0, 4'h0, 32'h0, 1, 1, 0, h5));
        vecs.push_back(idle(0, 1, 0, 1, 1, 1, h5));
        vecs.push_back(idle(0, 1, 0, 1, 1, 1, h5));
        // stall with both slots full
        vecs.push_back(mk(0, 1, 0, 1, 4'hA, 32'hA0, 32'hA4, 1, 1, 4'hB, 32'hB0, 1, 1, 1, h5));
        vecs.push_back(mk(0, 1, 0, 1, 4'hC, 32'hC0, 32'hC4, 0, 0, 4'h0, 32'h0, 1, 1, 0, ea));
        vecs.push_back(mk(0, 0, 0, 1, 4'hD, 32'hD0, 32'hD4, 1, 1, 4'hE, 32'hE0, 1, 0, 0, ea));
        vecs.push_back(mk(0, 0, 1, 1, 4'hD, 32'hD0, 32'hD4, 1, 1, 4'hE, 32'hE0, 1, 0, 0, ea));
        vecs.push_back(idle(0, 0, 0, 1, 0, 0, ea));
        vecs.push_back(idle(0, 1, 0, 1, 0, 1, cdb(1, 1, 4'hB, 32'hB0, 32'h0, 0)));
        vecs.push_back(idle(0, 1, 0, 1, 1, 1, cdb(1, 0, 4'hC, 32'hC0, 32'hC4, 0)));
        vecs.push_back(idle(0, 1, 0, 1, 1, 1, hc));
        // reset while RS id 4 is held
        vecs.push_back(mk(0, 1, 0, 1, 4'h4, 32'h40, 32'h48, 1, 0, 4'h0, 32'h0, 1, 1, 1, hc));
        vecs.push_back(idle(1, 1, 0, 0, 0, 0, z));
        vecs.push_back(idle(0, 1, 0, 1, 1, 1, z));
        vecs.push_back(idle(0, 1, 0, 1, 1, 1, z));

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; rdy = vecs[i].rdy; Clear_flag = vecs[i].clr;
            rs_valid = vecs[i].rv; rs_rob_id = vecs[i].rid; rs_value = vecs[i].rval;
            rs_jumppc = vecs[i].rjpc; rs_has_jumppc = vecs[i].rhj;
            slb_valid = vecs[i].sv; slb_rob_id = vecs[i].sid; slb_value = vecs[i].sval;
            #1;
            if (vecs[i].chk_rdy)
                chk($sformatf("vec%0d_ready", i), 128'({rs_ready, slb_ready}),
                    128'({vecs[i].exp_rr, vecs[i].exp_sr}));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_cdb", i), 128'(cdb_now()), 128'(vecs[i].exp_cdb));
        end

        // both sources stream for 8 cycles, then drain
        rs_sent = 0; slb_sent = 0; emitted = 0; exp_src = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            rst = 1'b0; rdy = 1'b1; Clear_flag = 1'b0;
            rs_valid = (c < 8); rs_rob_id = 4'(rs_sent);
            rs_value = 32'h100 + 32'(rs_sent); rs_jumppc = 32'h1000 + 32'(rs_sent);
            rs_has_jumppc = 1'b1;
            slb_valid = (c < 8); slb_rob_id = 4'(8 + slb_sent);
            slb_value = 32'h200 + 32'(8 + slb_sent);
            #1;
            rs_acc  = rs_valid && rs_ready;
            slb_acc = slb_valid && slb_ready;
            @(posedge clk);
            if (rs_acc) begin rs_q.push_back(rs_rob_id); rs_sent++; end
            if (slb_acc) begin slb_q.push_back(slb_rob_id); slb_sent++; end
            #1;
            if (cdb_valid) begin
                emitted++;
                if (exp_src == 1'b0) begin
                    id = (rs_q.size() > 0) ? rs_q.pop_front() : 4'hF;
                    chk($sformatf("stream_emit%0d", emitted), 128'(cdb_now()),
                        128'(cdb(1'b1, 1'b0, id, 32'h100 + 32'(id), 32'h1000 + 32'(id), 1'b1)));
                end else begin
                    id = (slb_q.size() > 0) ? slb_q.pop_front() : 4'hF;
                    chk($sformatf("stream_emit%0d", emitted), 128'(cdb_now()),
                        128'(cdb(1'b1, 1'b1, id, 32'h200 + 32'(id), 32'h0, 1'b0)));
                end
                exp_src = ~exp_src;
            end
        end
        chk("stream_rs_accepted", 128'(rs_sent), 128'(5));
        chk("stream_slb_accepted", 128'(slb_sent), 128'(4));
        chk("stream_emitted", 128'(emitted), 128'(9));
        chk("stream_leftover", 128'(rs_q.size() + slb_q.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
